// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: default register-file geometry and error-flag bit positions.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam int unsigned ERR_W    = 2;
    localparam int unsigned ERR_WCOL = 0;
    localparam int unsigned ERR_DRSV = 1;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy scoreboard for outstanding loads: reservation set, load-writeback clear,
// registered population count and sticky double-reservation flag.
module regfile_sb_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH    = NUM_REGS,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rsv,
    input  logic [AW-1:0] rsv_addr,
    input  logic          clr,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          ra1_busy,
    output logic          ra2_busy,
    output logic [CW-1:0] busy_count,
    output logic          drsv_err
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [CW-1:0]    count_nxt;
    logic             rsv_en;
    logic             clr_en;
    logic             drsv;

    assign rsv_en = rsv && !(ZERO_REG && rsv_addr == '0);
    assign clr_en = clr && !(ZERO_REG && clr_addr == '0);

    // A clear on the reserved address in the same cycle frees it first, so no double reservation.
    assign drsv = rsv_en && busy[rsv_addr] && !(clr_en && clr_addr == rsv_addr);

    // Next-state busy vector: set applied after clear so a same-cycle reservation wins.
    always_comb begin
        busy_nxt  = busy;
        count_nxt = '0;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count_nxt = count_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
            drsv_err   <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
            if (drsv) drsv_err <= 1'b1;
        end
    end

    function automatic logic lookup(input logic [AW-1:0] ra);
        logic b;
        b = 1'b0;
        if (!rst) begin
            b = busy[ra];
            if (BYPASS && clr_en && clr_addr == ra && !(rsv_en && rsv_addr == ra)) b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        ra1_busy = lookup(ra1);
        ra2_busy = lookup(ra2);
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-write-port register file with optional write-to-read bypass and a load busy scoreboard.
module regfile_sb
    import riscv_pkg::*;
#(
    parameter int unsigned N        = XLEN,
    parameter int unsigned DEPTH    = NUM_REGS,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [N-1:0]     rd1,
    output logic [N-1:0]     rd2,
    output logic             rd1_busy,
    output logic             rd2_busy,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [N-1:0]     wd1,
    input  logic             we2,
    input  logic [AW-1:0]    wa2,
    input  logic [N-1:0]     wd2,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    output logic [CW-1:0]    busy_count,
    output logic [ERR_W-1:0] err,
    input  logic [AW-1:0]    dbg_addr,
    output logic [N-1:0]     dbg_data
);

    logic [N-1:0] mem [DEPTH];
    logic         w1_en;
    logic         w2_en;
    logic         wcol_err;
    logic         drsv_err;

    assign w1_en = we1 && !(ZERO_REG && wa1 == '0);
    assign w2_en = we2 && !(ZERO_REG && wa2 == '0);

    // Port 1 assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wcol_err <= 1'b0;
        end else begin
            if (w2_en) mem[wa2] <= wd2;
            if (w1_en) mem[wa1] <= wd1;
            if (w1_en && w2_en && wa1 == wa2) wcol_err <= 1'b1;
        end
    end

    function automatic logic [N-1:0] stored(input logic [AW-1:0] a);
        return (ZERO_REG && a == '0) ? '0 : mem[a];
    endfunction

    function automatic logic [N-1:0] read_port(input logic [AW-1:0] ra);
        logic [N-1:0] d;
        d = stored(ra);
        if (BYPASS && !rst) begin
            if (w1_en && wa1 == ra)      d = wd1;
            else if (w2_en && wa2 == ra) d = wd2;
        end
        return d;
    endfunction

    always_comb begin
        rd1      = read_port(ra1);
        rd2      = read_port(ra2);
        dbg_data = stored(dbg_addr);
    end

    regfile_sb_scoreboard #(
        .DEPTH    (DEPTH),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rsv        (rsv),
        .rsv_addr   (rsv_addr),
        .clr        (we2),
        .clr_addr   (wa2),
        .ra1        (ra1),
        .ra2        (ra2),
        .ra1_busy   (rd1_busy),
        .ra2_busy   (rd2_busy),
        .busy_count (busy_count),
        .drsv_err   (drsv_err)
    );

    always_comb begin
        err           = '0;
        err[ERR_WCOL] = wcol_err;
        err[ERR_DRSV] = drsv_err;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing instance and a non-bypassing one on shared inputs.
module tb_regfile_sb;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra1, ra2, wa1, wa2, rsv_addr, dbg_addr;
    logic [31:0]   wd1, wd2;
    logic          we1, we2, rsv;

    logic [31:0]   rd1, rd2, dbg_data;
    logic          rd1_busy, rd2_busy;
    logic [CW-1:0] busy_count;
    logic [1:0]    err;

    logic [31:0]   nb_rd1, nb_rd2, nb_dbg_data;
    logic          nb_rd1_busy, nb_rd2_busy;
    logic [CW-1:0] nb_busy_count;
    logic [1:0]    nb_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_sb #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .we1(we1), .wa1(wa1), .wd1(wd1), .we2(we2), .wa2(wa2), .wd2(wd2),
        .rsv(rsv), .rsv_addr(rsv_addr), .busy_count(busy_count), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_sb #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
        .rd1_busy(nb_rd1_busy), .rd2_busy(nb_rd2_busy),
        .we1(we1), .wa1(wa1), .wd1(wd1), .we2(we2), .wa2(wa2), .wd2(wd2),
        .rsv(rsv), .rsv_addr(rsv_addr), .busy_count(nb_busy_count), .err(nb_err),
        .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we1 = 1'b0; we2 = 1'b0; rsv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; idle();
        ra1 = '0; ra2 = '0; wa1 = '0; wa2 = '0; rsv_addr = '0; dbg_addr = '0;
        wd1 = '0; wd2 = '0;
        tick();
        rst = 1'b0;
        #1;

        // Post-reset state across every address
        for (int a = 0; a < 32; a++) begin
            ra1 = AW'(a); ra2 = AW'(31 - a);
            #1;
            chk("rst_rd1", rd1, 32'h0);
            chk("rst_rd2", rd2, 32'h0);
            chk("rst_busy", 32'({rd1_busy, rd2_busy}), 32'h0);
        end
        chk("rst_count", 32'(busy_count), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Basic write with same-cycle read
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF; ra1 = 5'd5; dbg_addr = 5'd5;
        #1;
        chk("wr_bypass", rd1, 32'hDEADBEEF);
        chk("wr_nobypass", nb_rd1, 32'h0);
        chk("wr_dbg_pre", dbg_data, 32'h0);
        tick(); idle();
        chk("wr_dbg_post", dbg_data, 32'hDEADBEEF);
        chk("wr_nb_post", nb_rd1, 32'hDEADBEEF);

        // Zero register: write and reservation both dropped
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234; ra1 = 5'd0; rsv = 1'b1; rsv_addr = 5'd0;
        #1;
        chk("zero_bypass", rd1, 32'h0);
        tick(); idle(); dbg_addr = 5'd0;
        #1;
        chk("zero_rd", rd1, 32'h0);
        chk("zero_dbg", dbg_data, 32'h0);
        chk("zero_count", 32'(busy_count), 32'h0);
        chk("zero_err", 32'(err), 32'h0);

        // Collision on address 7
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h11; we2 = 1'b1; wa2 = 5'd7; wd2 = 32'h22; ra1 = 5'd7;
        #1;
        chk("col_bypass", rd1, 32'h11);
        tick(); idle(); dbg_addr = 5'd7;
        #1;
        chk("col_stored", dbg_data, 32'h11);
        chk("col_err", 32'(err), 32'h1);
        tick();
        chk("col_sticky", 32'(err), 32'h1);

        // Scoreboard: reserve 9 and 18
        rsv = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_addr = 5'd18;
        tick(); idle(); ra1 = 5'd9; ra2 = 5'd18;
        #1;
        chk("sb_count2", 32'(busy_count), 32'd2);
        chk("sb_busy9", 32'(rd1_busy), 32'h1);
        chk("sb_busy18", 32'(rd2_busy), 32'h1);

        // Load writeback to 9: bypassed data and masked busy
        we2 = 1'b1; wa2 = 5'd9; wd2 = 32'hA5;
        #1;
        chk("ld_bypass", rd1, 32'hA5);
        chk("ld_busy_mask", 32'(rd1_busy), 32'h0);
        chk("ld_nb_data", nb_rd1, 32'h0);
        chk("ld_nb_busy", 32'(nb_rd1_busy), 32'h1);
        tick(); idle();
        chk("ld_count1", 32'(busy_count), 32'd1);
        chk("ld_busy9", 32'(rd1_busy), 32'h0);
        chk("ld_data9", rd1, 32'hA5);

        // Same-cycle reserve and load writeback on 6: set wins
        rsv = 1'b1; rsv_addr = 5'd6; we2 = 1'b1; wa2 = 5'd6; wd2 = 32'h66; ra1 = 5'd6;
        tick(); idle(); dbg_addr = 5'd6;
        #1;
        chk("sim_busy6", 32'(rd1_busy), 32'h1);
        chk("sim_count", 32'(busy_count), 32'd2);
        chk("sim_data", dbg_data, 32'h66);
        chk("sim_err", 32'(err), 32'h1);

        // Reserve a busy register that is cleared the same cycle: no error, busy not masked
        rsv = 1'b1; rsv_addr = 5'd6; we2 = 1'b1; wa2 = 5'd6; wd2 = 32'h67;
        #1;
        chk("rc_busy_nomask", 32'(rd1_busy), 32'h1);
        tick(); idle();
        chk("rc_err", 32'(err), 32'h1);
        chk("rc_count", 32'(busy_count), 32'd2);
        chk("rc_data", dbg_data, 32'h67);

        // Double reservation on 18
        rsv = 1'b1; rsv_addr = 5'd18;
        tick(); idle(); ra2 = 5'd18;
        #1;
        chk("drsv_err", 32'(err), 32'h3);
        chk("drsv_count", 32'(busy_count), 32'd2);
        chk("drsv_busy", 32'(rd2_busy), 32'h1);

        // Load writeback to a non-busy register is legal
        we2 = 1'b1; wa2 = 5'd12; wd2 = 32'h55;
        tick(); idle(); dbg_addr = 5'd12;
        #1;
        chk("nb_ld_data", dbg_data, 32'h55);
        chk("nb_ld_err", 32'(err), 32'h3);
        chk("nb_ld_count", 32'(busy_count), 32'd2);

        // Mid-sequence reset: bypass and busy suppressed, writes/reservations ignored
        rst = 1'b1; we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hFF; rsv = 1'b1; rsv_addr = 5'd3;
        ra1 = 5'd5; ra2 = 5'd6;
        #1;
        chk("rst_nobypass", rd1, 32'hDEADBEEF);
        chk("rst_busy_sup", 32'(rd2_busy), 32'h0);
        tick(); rst = 1'b0; idle(); dbg_addr = 5'd5; ra1 = 5'd3;
        #1;
        chk("rst2_count", 32'(busy_count), 32'h0);
        chk("rst2_err", 32'(err), 32'h0);
        chk("rst2_data", dbg_data, 32'h0);
        chk("rst2_busy6", 32'(rd2_busy), 32'h0);
        chk("rst2_busy3", 32'(rd1_busy), 32'h0);
        chk("rst2_nb_count", 32'(nb_busy_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
